actor_move_scheduler: RTL
=========================

// Module: actor_move_scheduler
// PURPOSE
//  Per-game-tick movement sequencer for Pac-Man and the four ghosts. On each tick it walks actors 0..4
//  (0 = player, 1..4 = ghost1..4), computes each candidate next tile and checks it on one shared
//  wall-lookup port (req/ack to the walls tilemap). It then commits or holds each tile position.
//  Tile positions feed the pixel-position logic that drives DrawMap.
// PARAMETERS
//  COLS        28  tile columns; column wrap-around limit
//  ROWS        31  tile rows
//  COL_W       5   column index width
//  ROW_W       5   row index width
//  P_COL0      13  player reset column;  P_ROW0 23  player reset row
//  G_COL0      12  ghost1 reset column (ghost i = G_COL0+i-1);  G_ROW0 11  ghost reset row
// PORTS
//  clk          in   1        system clock; reset is synchronous and active-high
//  reset        in   1        synchronous, active-high
//  tick         in   1        one-cycle game-update pulse (5 Hz divider edge, already synchronised)
//  dir_valid    in   1        player direction key pressed this cycle
//  dir_in       in   2        0=up(w) 1=left(a) 2=down(s) 3=right(d)
//  ghost_dir    in   8        ghost i direction = ghost_dir[2i-1:2i-2], same encoding; sampled on tick
//  wall_req     out  1        lookup request; held until acked
//  wall_col     out  COL_W    lookup column, stable while wall_req=1
//  wall_row     out  ROW_W    lookup row, stable while wall_req=1
//  wall_ack     in   1        lookup complete; ignored while wall_req=0
//  wall_hit     in   1        1 = tile is wall; valid only in ack cycle
//  player_col   out  COL_W;  player_row out ROW_W
//  ghost_cols   out  4*COL_W  ghost i at [i*COL_W-1 -: COL_W];  ghost_rows out 4*ROW_W, same packing
//  busy         out  1        sequence in progress
//  done         out  1        one-cycle pulse: all five actors processed
//  overrun_cnt  out  8        ticks dropped while busy, saturates at 255
// BEHAVIOUR
//  Reset: positions = P_*/G_* values; want_dir=cur_dir=1 (left); wall_req=0, busy=0, done=0,
//   overrun_cnt=0, state=IDLE. Reset mid-sequence aborts; wall_req drops the next cycle; no partial commit.
//  want_dir <= dir_in whenever dir_valid=1, in any state. Lookups use the value latched at tick.
//  States: IDLE -> CALC -> REQ -> COMMIT -> (CALC next actor | DONE) -> IDLE.
//  IDLE: tick=1 -> latch ghost_dir and want_dir; idx=0; busy=1; go to CALC.
//  CALC (1 cycle): candidate = pos + step(dir).
//   dir = want_dir (first try) or cur_dir (player retry); ghosts use their latched direction.
//  Col wrap: col 0 moving left -> COLS-1; col COLS-1 moving right -> 0 (tunnel).
//  Row edge: row 0 up or row ROWS-1 down = implicit wall; skip REQ, go straight to COMMIT with hit=1.
//  REQ: wall_req=1 with candidate on wall_col/row; leave when wall_ack=1 (an ack in the first REQ cycle
//   counts); capture wall_hit.
//  COMMIT (1 cycle): hit=0 -> pos <= candidate; player also sets cur_dir <= tried dir.
//   Player hit on first try (want_dir != cur_dir) -> back to CALC with cur_dir (second lookup).
//   Player hit with want_dir==cur_dir, or hit on retry -> hold.
//   Ghost hit -> hold.
//   Then idx+1 -> CALC, or idx==4 -> DONE.
//  DONE: done=1 for one cycle, busy=0 that same cycle, then IDLE. The positions seen in the DONE cycle
//   are final.
//  Latency with zero-wait ack: 3 cycles per lookup.
//   Five single-lookup actors: tick at cycle T -> done at T+16.
//  tick while state!=IDLE (DONE included) is dropped: overrun_cnt += 1, saturating.
//  tick and dir_valid in the same cycle: the new dir_in is the one latched.
//  Outputs are registered; no combinational path from any input to any output.
// TESTING
//  1 Reset, then idle 10 cycles -> player (13,23), ghost1..4 cols 12..15 row 11; wall_req=0, busy=0.
//  2 Zero-wait ack, hit=0, all dirs=left, tick -> exactly 5 wall_req handshakes; done at T+16;
//    player col 12, ghost cols 11..14.
//  3 Player at col 0 heading left, hit=0, tick -> lookup col 27 row 23; player col becomes 27.
//  4 Player cur=left, dir_in=up, tile above is wall -> 2 lookups ((13,22) then (12,23));
//    player moves to col 12, cur_dir stays left.
//  5 Ack delayed 4 cycles -> wall_col/row stable throughout REQ; tick mid-sequence -> overrun_cnt=1,
//    no extra sequence.
//  6 reset asserted while in REQ -> wall_req=0 next cycle; all positions at reset values.

Source files
------------

// File: rtl/actor_move_scheduler.sv
// rtl/actor_move_scheduler.sv - per-tick movement sequencer for the player and four ghosts
// Ports:
//   clk, reset              clock; synchronous active-high reset
//   tick                    one-cycle game-update pulse that starts a sequence
//   dir_valid, dir_in       player direction key (0=up 1=left 2=down 3=right)
//   ghost_dir               ghost i direction at [2i-1:2i-2], sampled on tick
//   wall_req/col/row        shared wall lookup request, held until wall_ack
//   wall_ack, wall_hit      lookup completion and result (hit valid in ack cycle)
//   player_col/row          player tile position
//   ghost_cols/rows         ghost i tile at [i*W-1 -: W]
//   busy, done              sequence in progress / one-cycle completion pulse
//   overrun_cnt             saturating count of ticks dropped while not idle
module actor_move_scheduler #(
  parameter int COLS   = 28,
  parameter int ROWS   = 31,
  parameter int COL_W  = 5,
  parameter int ROW_W  = 5,
  parameter int P_COL0 = 13,
  parameter int P_ROW0 = 23,
  parameter int G_COL0 = 12,
  parameter int G_ROW0 = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               dir_valid,
  input  logic [1:0]         dir_in,
  input  logic [7:0]         ghost_dir,
  output logic               wall_req,
  output logic [COL_W-1:0]   wall_col,
  output logic [ROW_W-1:0]   wall_row,
  input  logic               wall_ack,
  input  logic               wall_hit,
  output logic [COL_W-1:0]   player_col,
  output logic [ROW_W-1:0]   player_row,
  output logic [4*COL_W-1:0] ghost_cols,
  output logic [4*ROW_W-1:0] ghost_rows,
  output logic               busy,
  output logic               done,
  output logic [7:0]         overrun_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_REQ, S_COMMIT, S_DONE} state_t;

  localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS - 1);
  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_LEFT  = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  state_t           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic             retry_q, retry_d;
  logic             hit_q, hit_d;
  logic [1:0]       want_dir_q, want_dir_d;
  logic [1:0]       cur_dir_q, cur_dir_d;
  logic [1:0]       lat_dir_q, lat_dir_d;
  logic [1:0]       try_dir_q, try_dir_d;
  logic [7:0]       gdir_q, gdir_d;
  logic [COL_W-1:0] cand_col_q, cand_col_d, pcol_q, pcol_d;
  logic [ROW_W-1:0] cand_row_q, cand_row_d, prow_q, prow_d;
  logic [COL_W-1:0] gcol_q [4];
  logic [COL_W-1:0] gcol_d [4];
  logic [ROW_W-1:0] grow_q [4];
  logic [ROW_W-1:0] grow_d [4];
  logic             wall_req_q, wall_req_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [7:0]       ovr_q, ovr_d;

  logic [1:0]       gi;
  logic [COL_W-1:0] act_col, next_col;
  logic [ROW_W-1:0] act_row, next_row;
  logic [1:0]       act_dir;
  logic             row_edge;

  // Actor under service: idx 0 is the player, idx 1..4 map to ghost slots 0..3.
  always_comb begin
    gi = 2'(idx_q - 3'd1);
    if (idx_q == 3'd0) begin
      act_col = pcol_q;
      act_row = prow_q;
      act_dir = retry_q ? cur_dir_q : lat_dir_q;
    end else begin
      act_col = gcol_q[gi];
      act_row = grow_q[gi];
      act_dir = gdir_q[{gi, 1'b0} +: 2];
    end
  end

  // Candidate tile: columns wrap through the tunnel, rows stop at the maze edge.
  always_comb begin
    next_col = act_col;
    next_row = act_row;
    row_edge = 1'b0;
    unique case (act_dir)
      DIR_UP: begin
        if (act_row == '0) row_edge = 1'b1;
        else               next_row = act_row - ROW_W'(1);
      end
      DIR_LEFT:  next_col = (act_col == '0) ? COL_MAX : act_col - COL_W'(1);
      DIR_DOWN: begin
        if (act_row == ROW_MAX) row_edge = 1'b1;
        else                    next_row = act_row + ROW_W'(1);
      end
      DIR_RIGHT: next_col = (act_col == COL_MAX) ? '0 : act_col + COL_W'(1);
    endcase
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    retry_d    = retry_q;
    hit_d      = hit_q;
    want_dir_d = dir_valid ? dir_in : want_dir_q;
    cur_dir_d  = cur_dir_q;
    lat_dir_d  = lat_dir_q;
    try_dir_d  = try_dir_q;
    gdir_d     = gdir_q;
    cand_col_d = cand_col_q;
    cand_row_d = cand_row_q;
    pcol_d     = pcol_q;
    prow_d     = prow_q;
    gcol_d     = gcol_q;
    grow_d     = grow_q;
    wall_req_d = wall_req_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ovr_d      = ovr_q;

    if (tick && state_q != S_IDLE && ovr_q != 8'hFF) ovr_d = ovr_q + 8'd1;

    unique case (state_q)
      S_IDLE: begin
        if (tick) begin
          lat_dir_d = want_dir_d;
          gdir_d    = ghost_dir;
          idx_d     = 3'd0;
          retry_d   = 1'b0;
          busy_d    = 1'b1;
          state_d   = S_CALC;
        end
      end
      S_CALC: begin
        cand_col_d = next_col;
        cand_row_d = next_row;
        try_dir_d  = act_dir;
        if (row_edge) begin
          hit_d   = 1'b1;
          state_d = S_COMMIT;
        end else begin
          wall_req_d = 1'b1;
          state_d    = S_REQ;
        end
      end
      S_REQ: begin
        if (wall_ack) begin
          hit_d      = wall_hit;
          wall_req_d = 1'b0;
          state_d    = S_COMMIT;
        end
      end
      S_COMMIT: begin
        if (!hit_q) begin
          if (idx_q == 3'd0) begin
            pcol_d    = cand_col_q;
            prow_d    = cand_row_q;
            cur_dir_d = try_dir_q;
          end else begin
            gcol_d[gi] = cand_col_q;
            grow_d[gi] = cand_row_q;
          end
        end
        // A blocked turn request falls back to the current heading once.
        if (hit_q && idx_q == 3'd0 && !retry_q && lat_dir_q != cur_dir_q) begin
          retry_d = 1'b1;
          state_d = S_CALC;
        end else begin
          retry_d = 1'b0;
          if (idx_q == 3'd4) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = S_CALC;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= 3'd0;
      retry_q    <= 1'b0;
      hit_q      <= 1'b0;
      want_dir_q <= DIR_LEFT;
      cur_dir_q  <= DIR_LEFT;
      lat_dir_q  <= DIR_LEFT;
      try_dir_q  <= DIR_LEFT;
      gdir_q     <= 8'd0;
      cand_col_q <= '0;
      cand_row_q <= '0;
      pcol_q     <= COL_W'(P_COL0);
      prow_q     <= ROW_W'(P_ROW0);
      for (int i = 0; i < 4; i++) begin
        gcol_q[i] <= COL_W'(G_COL0 + i);
        grow_q[i] <= ROW_W'(G_ROW0);
      end
      wall_req_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovr_q      <= 8'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      retry_q    <= retry_d;
      hit_q      <= hit_d;
      want_dir_q <= want_dir_d;
      cur_dir_q  <= cur_dir_d;
      lat_dir_q  <= lat_dir_d;
      try_dir_q  <= try_dir_d;
      gdir_q     <= gdir_d;
      cand_col_q <= cand_col_d;
      cand_row_q <= cand_row_d;
      pcol_q     <= pcol_d;
      prow_q     <= prow_d;
      for (int i = 0; i < 4; i++) begin
        gcol_q[i] <= gcol_d[i];
        grow_q[i] <= grow_d[i];
      end
      wall_req_q <= wall_req_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovr_q      <= ovr_d;
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      ghost_cols[i*COL_W +: COL_W] = gcol_q[i];
      ghost_rows[i*ROW_W +: ROW_W] = grow_q[i];
    end
  end

  assign wall_req    = wall_req_q;
  assign wall_col    = cand_col_q;
  assign wall_row    = cand_row_q;
  assign player_col  = pcol_q;
  assign player_row  = prow_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign overrun_cnt = ovr_q;

endmodule
